// File: rtl/shop_pkg.sv
// Shared constants for the shop command path: token geometry, ASCII delimiters, token-rx state encoding.
// Combinational only; no latency or backpressure.
package shop_pkg;

    localparam int NUM_ASCII_CHARS = 7;
    localparam int A_NUM_BITS      = NUM_ASCII_CHARS * 8;
    localparam int U_NUM_BITS      = 4;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_t;

    function automatic logic is_delim(input logic [7:0] c);
        return (c == ASCII_SP) || (c == ASCII_LF) || (c == ASCII_CR);
    endfunction

endpackage

// File: rtl/shop_dec_acc.sv
// Decimal digit detect plus one saturating acc*10+digit step.
// Purely combinational; no latency, no backpressure.
module shop_dec_acc #(
    parameter int U_NUM_BITS = 4
) (
    input  logic [U_NUM_BITS-1:0] acc,
    input  logic [7:0]            ch,
    output logic                  is_digit,
    output logic [U_NUM_BITS-1:0] acc_next
);
    // Four spare bits hold acc_max*10+9 without wrapping before the clamp.
    localparam int W = U_NUM_BITS + 4;
    localparam logic [U_NUM_BITS-1:0] ACC_MAX = '1;

    logic [7:0]   digit8;
    logic [W-1:0] wide;

    always_comb begin
        is_digit = (ch >= 8'h30) && (ch <= 8'h39);
        digit8   = is_digit ? (ch - 8'h30) : 8'h00;
        wide     = W'(acc) * W'(10) + W'(digit8);
        acc_next = (wide > W'(ACC_MAX)) ? ACC_MAX : wide[U_NUM_BITS-1:0];
    end

endmodule

// File: rtl/shop_token_rx.sv
// Assembles delimiter-separated ASCII bytes into right-justified token words plus a saturated numeric value.
// o_rdy one cycle after the terminating delimiter; o_char_ready drops only for the single EMIT cycle.
module shop_token_rx
    import shop_pkg::*;
#(
    parameter int NUM_ASCII_CHARS = shop_pkg::NUM_ASCII_CHARS,
    parameter int A_NUM_BITS      = NUM_ASCII_CHARS * 8,
    parameter int U_NUM_BITS      = shop_pkg::U_NUM_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_char_valid,
    input  logic [7:0]            i_char,
    output logic                  o_char_ready,
    output logic                  o_rdy,
    output logic [A_NUM_BITS-1:0] o_a,
    output logic [U_NUM_BITS-1:0] o_u,
    output logic                  o_is_num,
    output logic                  o_err
);
    localparam int CW = $clog2(NUM_ASCII_CHARS + 1);

    rx_state_t             state, state_nxt;
    logic [A_NUM_BITS-1:0] shadow;
    logic [CW-1:0]         count;
    logic [U_NUM_BITS-1:0] num_acc;
    logic                  num_flag;

    logic                  accept;
    logic                  delim;
    logic                  full;
    logic                  dig;
    logic [U_NUM_BITS-1:0] acc_in;
    logic [U_NUM_BITS-1:0] acc_next;

    assign accept = i_char_valid && o_char_ready;
    assign delim  = is_delim(i_char);
    assign full   = (count == CW'(NUM_ASCII_CHARS));
    // The first char of a token starts a fresh accumulation.
    assign acc_in = (state == ST_IDLE) ? '0 : num_acc;

    shop_dec_acc #(.U_NUM_BITS(U_NUM_BITS)) u_dec_acc (
        .acc      (acc_in),
        .ch       (i_char),
        .is_digit (dig),
        .acc_next (acc_next)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept && !delim) state_nxt = ST_ACCUM;
            ST_ACCUM: if (accept) begin
                          if (delim)     state_nxt = ST_EMIT;
                          else if (full) state_nxt = ST_DRAIN;
                      end
            ST_EMIT:  state_nxt = ST_IDLE;
            ST_DRAIN: if (accept && delim) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rdy        = (state == ST_EMIT);
        o_char_ready = (state != ST_EMIT);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shadow   <= '0;
            count    <= '0;
            num_acc  <= '0;
            num_flag <= 1'b0;
            o_a      <= '0;
            o_u      <= '0;
            o_is_num <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (accept) begin
                unique case (state)
                    ST_IDLE: if (!delim) begin
                        shadow   <= {{(A_NUM_BITS-8){1'b0}}, i_char};
                        count    <= CW'(1);
                        num_acc  <= acc_next;
                        num_flag <= dig;
                    end
                    ST_ACCUM: begin
                        if (delim) begin
                            // Output word is loaded only here so it stays stable until the next token.
                            o_a      <= shadow;
                            o_u      <= num_flag ? num_acc : '0;
                            o_is_num <= num_flag;
                        end else if (full) begin
                            o_err <= 1'b1;
                        end else begin
                            shadow   <= {shadow[A_NUM_BITS-9:0], i_char};
                            count    <= count + CW'(1);
                            num_acc  <= acc_next;
                            num_flag <= num_flag && dig;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
